sreg_unit: RTL
==============

// Module: sreg_unit
// PURPOSE
//  AVR status register (SREG) stage, directly downstream of the ALU. Captures the
//  ALU flags (C,H,Z,V and result bit 7) under a per-flag mask, derives N and S,
//  and holds SREG = {I,T,H,S,V,N,Z,C}. Drives the ALU carry-in and sequences
//  two-cycle ADIW/SBIW word ops (carry/Z chained low byte -> high byte).
//  Also serves BSET/BCLR, OUT/STS to SREG, interrupt ack (clear I) and RETI (set I).
// PARAMETERS
//  RST_VAL  8'h00  SREG value loaded on reset
// PORTS
//  clk_i         in   1  system clock
//  rst_i         in   1  synchronous reset, active high
//  alu_c_i       in   1  ALU carry/borrow out
//  alu_h_i       in   1  ALU half carry out
//  alu_z_i       in   1  ALU zero (result == 0)
//  alu_v_i       in   1  ALU overflow
//  alu_n_i       in   1  ALU result bit 7
//  upd_mask_i    in   8  per-bit ALU update enable, SREG bit order; bits 7:6 ignored
//  zkeep_i       in   1  Z chaining (CPC/SBC/SBCI): Z <= Z & alu_z_i
//  use_c_i       in   1  1: alu_cin_o = C (ADC/SBC); 0: alu_cin_o = 0
//  word_start_i  in   1  current cycle is the low byte of ADIW/SBIW
//  bset_i        in   1  set SREG[bit_sel_i]
//  bclr_i        in   1  clear SREG[bit_sel_i]
//  bit_sel_i     in   3  bit index for BSET/BCLR
//  we_i          in   1  full SREG write (OUT/STS)
//  data_i        in   8  write data for we_i
//  irq_ack_i     in   1  interrupt accepted: clear I
//  reti_i        in   1  RETI: set I
//  sreg_o        out  8  current SREG
//  alu_cin_o     out  1  carry-in to ALU (combinational)
//  busy_o        out  1  high-byte cycle of a word op in progress
//  word_done_o   out  1  high during the high-byte cycle (SREG updated at its end)
// BEHAVIOUR
//  Reset: sreg_o=RST_VAL, FSM=IDLE, busy_o=0, word_done_o=0, internal cy/zlo=0.
//  All updates take effect at the next rising clk_i (1-cycle latency to sreg_o).
//  FSM IDLE: word_start_i -> latch cy=alu_c_i, zlo=alu_z_i; SREG not updated;
//    go HI. Otherwise apply single-byte update as below.
//  FSM HI: busy_o=1, word_done_o=1, alu_cin_o=cy; SREG: C=alu_c_i,
//    Z=zlo & alu_z_i, V=alu_v_i, N=alu_n_i, S=N^V (new values), H,T,I kept;
//    upd_mask_i ignored; word_start_i ignored; -> IDLE unconditionally.
//  alu_cin_o in IDLE = use_c_i & C.
//  Single-byte update per bit b in {5..0}, when upd_mask_i[b]:
//    C=alu_c_i; Z=zkeep_i ? (Z & alu_z_i) : alu_z_i; N=alu_n_i; V=alu_v_i;
//    H=alu_h_i; S=N_new ^ V_new (N_new/V_new = post-update values).
//  Priority per bit, low to high (higher overrides): ALU mask update <
//    bset_i/bclr_i (bset wins if both) < we_i (data_i, all 8 bits) <
//    reti_i (I=1) < irq_ack_i (I=0). Applies in IDLE and HI (HI replaces ALU step).
//  Reset during HI: FSM returns IDLE, no high-byte update, SREG=RST_VAL.
//  No other state; no back-pressure -- decoder must not issue word_start_i in HI.
// TESTING
//  ADD 0x80+0x80: alu c=1,z=1,v=1,n=0, mask 0x3F -> sreg_o=0x1B (S,V,Z,C).
//  ADIW 0x00FF+1: lo c=1,z=1; HI cin=1, hi z=0,n=0 -> C=0,Z=0; word_done_o 1 cycle.
//  SBIW 0x0001-1: lo z=1,c=0; hi z=1 -> Z=1,C=0,N=0,S=0; busy_o one cycle only.
//  CPC zkeep_i=1 with Z=0, alu_z=1 -> Z stays 0; with Z=1 -> Z=1.
//  bset_i bit7 + irq_ack_i same cycle -> I=0; we_i 0xA5 + bclr bit0 -> 0xA5.
//  rst_i in HI cycle -> sreg_o=0x00, busy_o=0 next cycle, no word update.

Source files
------------

// File: rtl/sreg_unit.sv
// sreg_unit: AVR status register stage sitting behind the ALU.
// Holds SREG = {I,T,H,S,V,N,Z,C}, applies masked ALU flag updates, and
// sequences the two-cycle ADIW/SBIW word operations (carry and zero are
// chained from the low-byte cycle into the high-byte cycle). BSET/BCLR,
// full SREG writes, RETI and interrupt acknowledge override the ALU step.
module sreg_unit #(
   parameter logic [7:0] RST_VAL = 8'h00
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       alu_c_i,
   input  logic       alu_h_i,
   input  logic       alu_z_i,
   input  logic       alu_v_i,
   input  logic       alu_n_i,
   input  logic [7:0] upd_mask_i,
   input  logic       zkeep_i,
   input  logic       use_c_i,
   input  logic       word_start_i,
   input  logic       bset_i,
   input  logic       bclr_i,
   input  logic [2:0] bit_sel_i,
   input  logic       we_i,
   input  logic [7:0] data_i,
   input  logic       irq_ack_i,
   input  logic       reti_i,
   output logic [7:0] sreg_o,
   output logic       alu_cin_o,
   output logic       busy_o,
   output logic       word_done_o
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HI   = 1'b1
   } state_t;

   state_t     state_r, state_nx_s;
   logic [7:0] sreg_r, sreg_nx_s, alu_upd_s;
   logic       cy_r, cy_nx_s;
   logic       zlo_r, zlo_nx_s;
   logic       n_new_s, v_new_s, z_new_s;
   logic       hi_n_s, hi_v_s;

   // I and T are never touched by the ALU, so the top mask bits carry no meaning.
   logic       unused_mask_s;
   assign unused_mask_s = ^upd_mask_i[7:6];

   // Single-byte ALU flag update; S is built from the post-update N and V.
   always_comb begin
      n_new_s   = upd_mask_i[2] ? alu_n_i : sreg_r[2];
      v_new_s   = upd_mask_i[3] ? alu_v_i : sreg_r[3];
      z_new_s   = upd_mask_i[1] ? (zkeep_i ? (sreg_r[1] & alu_z_i) : alu_z_i) : sreg_r[1];
      alu_upd_s = {sreg_r[7:6],
                   upd_mask_i[5] ? alu_h_i : sreg_r[5],
                   upd_mask_i[4] ? (n_new_s ^ v_new_s) : sreg_r[4],
                   v_new_s,
                   n_new_s,
                   z_new_s,
                   upd_mask_i[0] ? alu_c_i : sreg_r[0]};
   end

   // Next-state, chained word-op latches and prioritised SREG next value.
   always_comb begin
      state_nx_s = state_r;
      sreg_nx_s  = sreg_r;
      cy_nx_s    = cy_r;
      zlo_nx_s   = zlo_r;
      hi_n_s     = alu_n_i;
      hi_v_s     = alu_v_i;
      case (state_r)
         ST_IDLE: begin
            if (word_start_i) begin
               cy_nx_s    = alu_c_i;
               zlo_nx_s   = alu_z_i;
               state_nx_s = ST_HI;
            end else begin
               sreg_nx_s  = alu_upd_s;
            end
         end
         ST_HI: begin
            // High byte: full flag set from the ALU, Z chained with the low byte.
            sreg_nx_s  = {sreg_r[7:5], hi_n_s ^ hi_v_s, hi_v_s, hi_n_s,
                          zlo_r & alu_z_i, alu_c_i};
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase

      if (bset_i) begin
         sreg_nx_s[bit_sel_i] = 1'b1;
      end else if (bclr_i) begin
         sreg_nx_s[bit_sel_i] = 1'b0;
      end else begin
         sreg_nx_s = sreg_nx_s;
      end

      if (we_i) begin
         sreg_nx_s = data_i;
      end else begin
         sreg_nx_s = sreg_nx_s;
      end

      if (irq_ack_i) begin
         sreg_nx_s[7] = 1'b0;
      end else if (reti_i) begin
         sreg_nx_s[7] = 1'b1;
      end else begin
         sreg_nx_s[7] = sreg_nx_s[7];
      end
   end

   // State, SREG and word-op latches with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
         sreg_r  <= RST_VAL;
         cy_r    <= 1'b0;
         zlo_r   <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         sreg_r  <= sreg_nx_s;
         cy_r    <= cy_nx_s;
         zlo_r   <= zlo_nx_s;
      end
   end

   // Carry-in: chained low-byte carry during the high byte, else optional C.
   always_comb begin
      if (state_r == ST_HI) begin
         alu_cin_o = cy_r;
      end else begin
         alu_cin_o = use_c_i & sreg_r[0];
      end
   end

   assign sreg_o      = sreg_r;
   assign busy_o      = (state_r == ST_HI);
   assign word_done_o = (state_r == ST_HI);

endmodule
